// File: rtl/div_ctrl_pkg.sv
// Shared widths, funct encodings and FSM states for the EX-stage divide sequencer.
package div_ctrl_pkg;

  localparam int DATA_BUS  = 32;
  localparam int FUNCT_BUS = 3;

  localparam logic [FUNCT_BUS-1:0] FUNCT_DIV  = 3'b100;
  localparam logic [FUNCT_BUS-1:0] FUNCT_DIVU = 3'b101;
  localparam logic [FUNCT_BUS-1:0] FUNCT_REM  = 3'b110;
  localparam logic [FUNCT_BUS-1:0] FUNCT_REMU = 3'b111;

  localparam logic [DATA_BUS-1:0] SIGNED_MIN = 32'h8000_0000;
  localparam logic [DATA_BUS-1:0] ALL_ONES   = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  // DIV and REM are signed; the U variants have funct[0] set.
  function automatic logic is_signed_op(input logic [FUNCT_BUS-1:0] f);
    return ~f[0];
  endfunction

  // REM/REMU have funct[1] set and return the remainder.
  function automatic logic [DATA_BUS-1:0] pick_result(input logic [FUNCT_BUS-1:0] f,
                                                      input logic [DATA_BUS-1:0]  quo,
                                                      input logic [DATA_BUS-1:0]  rem);
    return f[1] ? rem : quo;
  endfunction

endpackage

// File: rtl/div_cache.sv
// One-entry cache of the last divider result, tagged by operands and signedness.
module div_cache
  import div_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_wr_en,
  input  logic [DATA_BUS-1:0] i_wr_op1,
  input  logic [DATA_BUS-1:0] i_wr_op2,
  input  logic                i_wr_signed,
  input  logic [DATA_BUS-1:0] i_wr_quo,
  input  logic [DATA_BUS-1:0] i_wr_rem,
  input  logic [DATA_BUS-1:0] i_lk_op1,
  input  logic [DATA_BUS-1:0] i_lk_op2,
  input  logic                i_lk_signed,
  output logic                o_hit,
  output logic [DATA_BUS-1:0] o_quo,
  output logic [DATA_BUS-1:0] o_rem
);

  logic                r_valid;
  logic                r_signed;
  logic [DATA_BUS-1:0] r_op1;
  logic [DATA_BUS-1:0] r_op2;
  logic [DATA_BUS-1:0] r_quo;
  logic [DATA_BUS-1:0] r_rem;

  // Only reset clears the valid bit; writes simply replace the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid  <= 1'b0;
      r_signed <= 1'b0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_quo    <= '0;
      r_rem    <= '0;
    end else if (i_wr_en) begin
      r_valid  <= 1'b1;
      r_signed <= i_wr_signed;
      r_op1    <= i_wr_op1;
      r_op2    <= i_wr_op2;
      r_quo    <= i_wr_quo;
      r_rem    <= i_wr_rem;
    end
  end

  assign o_hit = r_valid && (r_op1 == i_lk_op1) && (r_op2 == i_lk_op2)
                 && (r_signed == i_lk_signed);
  assign o_quo = r_quo;
  assign o_rem = r_rem;

endmodule

// File: rtl/div_ctrl.sv
// Multi-cycle sequencer in front of the combinational Divider: holds operands,
// stalls the pipe, and short-circuits div-by-zero, overflow and repeated operands.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int DIV_CYCLES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 ex_valid,
  input  logic                 div_en,
  input  logic [FUNCT_BUS-1:0] funct,
  input  logic [DATA_BUS-1:0]  operand_1,
  input  logic [DATA_BUS-1:0]  operand_2,
  output logic [DATA_BUS-1:0]  div_operand_1,
  output logic [DATA_BUS-1:0]  div_operand_2,
  output logic [FUNCT_BUS-1:0] div_funct,
  output logic                 div_start,
  input  logic [DATA_BUS-1:0]  div_quo,
  input  logic [DATA_BUS-1:0]  div_rem,
  output logic                 stall_req,
  output logic [DATA_BUS-1:0]  result,
  output logic                 result_valid,
  output logic [1:0]           o_dbg_state
);

  localparam logic [3:0] CNT_INIT = 4'(DIV_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [3:0]           r_cnt;
  logic [3:0]           w_cnt_nxt;
  logic [DATA_BUS-1:0]  r_op1;
  logic [DATA_BUS-1:0]  r_op2;
  logic [FUNCT_BUS-1:0] r_funct;
  logic [DATA_BUS-1:0]  r_result;

  logic                 w_start;
  logic                 w_signed;
  logic                 w_div0;
  logic                 w_ovf;
  logic                 w_hit;
  logic                 w_cache_wr;
  logic [DATA_BUS-1:0]  w_cache_quo;
  logic [DATA_BUS-1:0]  w_cache_rem;
  logic                 w_load;
  logic                 w_set_res;
  logic [DATA_BUS-1:0]  w_quo_nxt;
  logic [DATA_BUS-1:0]  w_rem_nxt;
  logic [FUNCT_BUS-1:0] w_res_funct;

  // rst_n gates start so a request held during reset never raises stall_req.
  assign w_start  = (r_state == IDLE) && ex_valid && div_en && !flush && rst_n;
  assign w_signed = is_signed_op(funct);
  assign w_div0   = (operand_2 == '0);
  assign w_ovf    = w_signed && (operand_1 == SIGNED_MIN) && (operand_2 == ALL_ONES);

  // Only a completed divider run fills the cache, never a fast-path result.
  assign w_cache_wr = (r_state == BUSY) && (r_cnt == 4'd0) && !flush;

  div_cache u_cache (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (w_cache_wr),
    .i_wr_op1    (r_op1),
    .i_wr_op2    (r_op2),
    .i_wr_signed (is_signed_op(r_funct)),
    .i_wr_quo    (div_quo),
    .i_wr_rem    (div_rem),
    .i_lk_op1    (operand_1),
    .i_lk_op2    (operand_2),
    .i_lk_signed (w_signed),
    .o_hit       (w_hit),
    .o_quo       (w_cache_quo),
    .o_rem       (w_cache_rem)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    w_set_res   = 1'b0;
    w_quo_nxt   = '0;
    w_rem_nxt   = '0;
    w_res_funct = r_funct;
    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_load      = 1'b1;
          w_res_funct = funct;
          if (w_div0) begin
            w_quo_nxt   = ALL_ONES;
            w_rem_nxt   = operand_1;
            w_set_res   = 1'b1;
            w_state_nxt = DONE;
          end else if (w_ovf) begin
            w_quo_nxt   = SIGNED_MIN;
            w_rem_nxt   = '0;
            w_set_res   = 1'b1;
            w_state_nxt = DONE;
          end else if (w_hit) begin
            w_quo_nxt   = w_cache_quo;
            w_rem_nxt   = w_cache_rem;
            w_set_res   = 1'b1;
            w_state_nxt = DONE;
          end else begin
            w_cnt_nxt   = CNT_INIT;
            w_state_nxt = BUSY;
          end
        end
      end
      BUSY: begin
        if (flush) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = IDLE;
        end else if (r_cnt != 4'd0) begin
          w_cnt_nxt = r_cnt - 4'd1;
        end else begin
          w_quo_nxt   = div_quo;
          w_rem_nxt   = div_rem;
          w_set_res   = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_cnt    <= 4'd0;
      r_op1    <= '0;
      r_op2    <= '0;
      r_funct  <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_op1   <= operand_1;
        r_op2   <= operand_2;
        r_funct <= funct;
      end
      if (w_set_res) r_result <= pick_result(w_res_funct, w_quo_nxt, w_rem_nxt);
    end
  end

  assign div_operand_1 = r_op1;
  assign div_operand_2 = r_op2;
  assign div_funct     = r_funct;
  assign div_start     = (r_state == BUSY);
  assign stall_req     = (w_start || (r_state == BUSY)) && !flush;
  assign result_valid  = (r_state == DONE) && !flush;
  assign result        = r_result;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_div_ctrl.sv
// Bench for div_ctrl: models the Divider beside it, a reference divide/cache model,
// directed corner cases and randomized back-to-back ops.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  localparam int DIV_CYCLES = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush, ex_valid, div_en;
  logic [2:0]  funct;
  logic [31:0] operand_1, operand_2;
  logic [31:0] div_operand_1, div_operand_2;
  logic [2:0]  div_funct;
  logic        div_start;
  logic [31:0] div_quo, div_rem;
  logic        stall_req;
  logic [31:0] result;
  logic        result_valid;
  logic [1:0]  o_dbg_state;

  int n_checks = 0;
  int n_pass   = 0;

  // reference cache state
  bit          m_valid = 1'b0;
  logic [31:0] m_a, m_b;
  bit          m_s;

  int hold;

  div_ctrl #(.DIV_CYCLES(DIV_CYCLES)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .flush         (flush),
    .ex_valid      (ex_valid),
    .div_en        (div_en),
    .funct         (funct),
    .operand_1     (operand_1),
    .operand_2     (operand_2),
    .div_operand_1 (div_operand_1),
    .div_operand_2 (div_operand_2),
    .div_funct     (div_funct),
    .div_start     (div_start),
    .div_quo       (div_quo),
    .div_rem       (div_rem),
    .stall_req     (stall_req),
    .result        (result),
    .result_valid  (result_valid),
    .o_dbg_state   (o_dbg_state)
  );

  always #5 clk = ~clk;

  // RISC-V divide semantics, returned as {quotient, remainder}.
  function automatic logic [63:0] ref_div(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a;
    end else if (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0;
    end else if (!f[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return {q, r};
  endfunction

  // Divider model: only settles after its inputs have been held DIV_CYCLES cycles.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)         hold <= 0;
    else if (div_start) hold <= hold + 1;
    else                hold <= 0;
  end

  always_comb begin
    logic [63:0] qr;
    qr = ref_div(div_funct, div_operand_1, div_operand_2);
    div_quo = qr[63:32];
    div_rem = qr[31:0];
    if (hold < DIV_CYCLES - 1) begin
      div_quo = 32'hDEAD_BEEF;
      div_rem = 32'hDEAD_BEEF;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Expected result and latency; a miss on the slow path fills the model cache.
  task automatic model_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] res, output int lat);
    logic [63:0] qr;
    bit sgn, fast;
    qr   = ref_div(f, a, b);
    res  = f[1] ? qr[31:0] : qr[63:32];
    sgn  = !f[0];
    fast = (b == 32'd0) || (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    if (fast) lat = 1;
    else if (m_valid && m_a == a && m_b == b && m_s == sgn) lat = 1;
    else begin
      lat = DIV_CYCLES + 1;
      m_valid = 1'b1; m_a = a; m_b = b; m_s = sgn;
    end
  endtask

  // Issue one op starting right after a posedge; flush_cyc < 0 means no flush.
  task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_res, input int exp_lat, input int flush_cyc,
                       input string tag);
    int  stalls = 0;
    bit  got = 1'b0;
    bit  ovl = 1'b0;
    ex_valid = 1'b1; div_en = 1'b1; funct = f; operand_1 = a; operand_2 = b;
    for (int cyc = 0; cyc < 40; cyc++) begin
      flush = (cyc == flush_cyc);
      @(negedge clk);
      if (stall_req) stalls++;
      if (stall_req && result_valid) ovl = 1'b1;
      if (cyc == 1 && (flush_cyc < 0 || flush_cyc > 1)) begin
        check({tag, " op1"}, div_operand_1, a);
        check({tag, " funct"}, 32'(div_funct), 32'(f));
      end
      if (cyc == flush_cyc) begin
        check({tag, " flush stall"}, 32'(stall_req), 32'd0);
        check({tag, " flush valid"}, 32'(result_valid), 32'd0);
      end
      if (result_valid) begin
        got = 1'b1;
        check({tag, " lat"}, 32'(cyc), 32'(exp_lat));
        check({tag, " result"}, result, exp_res);
      end
      @(posedge clk); #1;
      if (got || cyc == flush_cyc) break;
    end
    flush = 1'b0; ex_valid = 1'b0; div_en = 1'b0;
    check({tag, " overlap"}, 32'(ovl), 32'd0);
    if (flush_cyc < 0) begin
      check({tag, " done seen"}, 32'(got), 32'd1);
      check({tag, " stalls"}, 32'(stalls), 32'(exp_lat));
    end else begin
      check({tag, " no valid"}, 32'(got), 32'd0);
      @(negedge clk);
      check({tag, " idle after flush"}, 32'(o_dbg_state), 32'(IDLE));
      @(posedge clk); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] res, a, b;
    logic [2:0]  f;
    int          lat;

    // reset with a start request held
    rst_n = 1'b0; flush = 1'b0; ex_valid = 1'b1; div_en = 1'b1;
    funct = FUNCT_DIVU; operand_1 = 32'd100; operand_2 = 32'd7;
    repeat (3) @(negedge clk);
    check("rst stall", 32'(stall_req), 32'd0);
    check("rst valid", 32'(result_valid), 32'd0);
    check("rst start", 32'(div_start), 32'd0);
    check("rst result", result, 32'd0);
    check("rst op1", div_operand_1, 32'd0);
    check("rst state", 32'(o_dbg_state), 32'(IDLE));
    @(posedge clk); #1;
    ex_valid = 1'b0; div_en = 1'b0; rst_n = 1'b1;
    @(negedge clk);
    check("post rst state", 32'(o_dbg_state), 32'(IDLE));
    check("post rst result", result, 32'd0);
    check("post rst stall", 32'(stall_req), 32'd0);
    @(posedge clk); #1;

    // directed corner cases
    model_op(FUNCT_DIVU, 32'd100, 32'd7, res, lat);
    do_op(FUNCT_DIVU, 32'd100, 32'd7, 32'd14, 5, -1, "divu100_7");
    model_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, res, lat);
    do_op(FUNCT_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 5, -1, "div_m7_2");
    model_op(FUNCT_REM, 32'hFFFF_FFF9, 32'd2, res, lat);
    do_op(FUNCT_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1, -1, "rem_m7_2_hit");
    model_op(FUNCT_DIV, 32'd5, 32'd0, res, lat);
    do_op(FUNCT_DIV, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, -1, "div5_0");
    model_op(FUNCT_REMU, 32'd5, 32'd0, res, lat);
    do_op(FUNCT_REMU, 32'd5, 32'd0, 32'd5, 1, -1, "remu5_0");
    model_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    do_op(FUNCT_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, -1, "div_ovf");
    model_op(FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, res, lat);
    do_op(FUNCT_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, -1, "rem_ovf");
    do_op(FUNCT_DIVU, 32'd1000, 32'd3, 32'd0, 0, 2, "flush_busy");
    model_op(FUNCT_DIVU, 32'd1000, 32'd3, res, lat);
    do_op(FUNCT_DIVU, 32'd1000, 32'd3, 32'd333, 5, -1, "replay_miss");
    model_op(FUNCT_DIVU, 32'd77, 32'd5, res, lat);
    do_op(FUNCT_DIVU, 32'd77, 32'd5, 32'd0, 0, 5, "flush_done");
    model_op(FUNCT_REMU, 32'd77, 32'd5, res, lat);
    do_op(FUNCT_REMU, 32'd77, 32'd5, 32'd2, 1, -1, "remu_after_flush_done");

    // randomized back-to-back ops with repeated operands and corner values
    a = 32'd1; b = 32'd1;
    for (int i = 0; i < 60; i++) begin
      f = {1'b1, 2'($urandom_range(0, 3))};
      if ($urandom_range(0, 2) != 0) begin
        case ($urandom_range(0, 3))
          0: a = $urandom;
          1: a = 32'h8000_0000;
          2: a = 32'($urandom_range(0, 50));
          default: a = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        endcase
        case ($urandom_range(0, 3))
          0: b = $urandom;
          1: b = 32'd0;
          2: b = 32'hFFFF_FFFF;
          default: b = 32'($urandom_range(1, 9));
        endcase
      end
      model_op(f, a, b, res, lat);
      do_op(f, a, b, res, lat, -1, $sformatf("rnd%0d", i));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
# div_ctrl

Multi-cycle sequencer for the EX-stage divide path. It sits directly upstream of the combinational `Divider`. It latches DIV/DIVU/REM/REMU operands from the EX inputs and holds them stable on the divider inputs for a fixed multicycle window. While that window is open it stalls the pipeline, then captures the quotient and remainder and presents one registered result to the EX/MEM path. Divide-by-zero, signed overflow and repeated-operand cases (the DIV followed by REM idiom) bypass the divider through a fast path and a one-entry result cache.

## Interface
- `DIV_CYCLES`, default 4: cycles the divider inputs are held stable before capture. Legal range 1..15.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous active-low reset.
- `flush`  in  1  kill the instruction currently in EX.
- `ex_valid`  in  1  EX holds a valid instruction.
- `div_en`  in  1  the EX instruction is a divide-class op.
- `funct`  in  `FUNCT_BUS` (3)  `FUNCT_DIV`=100, `FUNCT_DIVU`=101, `FUNCT_REM`=110, `FUNCT_REMU`=111.
- `operand_1`, `operand_2`  in  32 each  dividend and divisor.
- `div_operand_1`, `div_operand_2`  out  32 each  registered operands to `Divider`.
- `div_funct`  out  3  registered funct to `Divider`.
- `div_start`  out  1  high while the `Divider` inputs are held.
- `div_quo`, `div_rem`  in  32 each  `Divider` quotient and remainder, sign-corrected.
- `stall_req`  out  1  hold IF/ID/EX this cycle.
- `result`  out  32  final quotient or remainder.
- `result_valid`  out  1  `result` is valid this cycle.

## Operation
- FSM states: IDLE, BUSY, DONE.
- Definitions:
  - start = IDLE & ex_valid & div_en & !flush.
  - Signed ops are DIV and REM.
- IDLE, on start: latch the operands and funct into the `div_*` registers, then:
  - **Divisor == 0:** quo = 0xFFFFFFFF, rem = operand_1. Go to DONE.
  - **Signed op, operand_1 == 0x80000000, operand_2 == 0xFFFFFFFF:** quo = 0x80000000, rem = 0. Go to DONE.
  - **Cache hit** (cache_valid, same operand_1, operand_2 and signedness): quo and rem come from the cache. Go to DONE.
  - **Otherwise:** cnt = DIV_CYCLES-1. Go to BUSY.
- BUSY:
  - `div_start`=1.
  - If cnt != 0: cnt decrements.
  - If cnt == 0: capture `div_quo` and `div_rem`, write the cache (operands, signedness, quo, rem, valid=1), go to DONE.
- DONE:
  - `result_valid`=1, `stall_req`=0.
  - `result` = quo for DIV/DIVU, rem for REM/REMU (from the latched funct).
  - Always go to IDLE next cycle. DONE never re-starts, because the same instruction is still in EX during DONE.
- `stall_req` = start | BUSY, forced to 0 when `flush`=1.
- Flush:
  - In BUSY or on a start cycle: abort and go to IDLE next cycle. No cache write.
  - In DONE: `result_valid` is suppressed and the FSM goes to IDLE.
- The cache is invalidated only by reset. Fast-path results never write the cache.
- Reset values:
  - State IDLE, cnt 0, cache_valid 0.
  - All data registers 0.
  - `stall_req`, `result_valid`, `div_start` = 0; `result` = 0.
- `stall_req` and `result_valid` are never high in the same cycle.

## Timing
- Cycle 0 = start cycle. `stall_req` is high combinationally in cycle 0.
- Normal path:
  - BUSY occupies cycles 1..DIV_CYCLES; the divider sees stable inputs from cycle 1.
  - DONE is cycle DIV_CYCLES+1.
  - Stall length is DIV_CYCLES+1 cycles.
- Fast path and cache hit: DONE in cycle 1, stall length 1 cycle.
- The next EX instruction is sampled in the cycle after DONE. Back-to-back divides therefore start with no bubble beyond their own stall.
- Reset asserted mid-operation: asynchronous return to the reset values. Deassertion resumes in IDLE.
- `result` holds its value outside DONE. Consumers qualify it with `result_valid`.

## Structure
- Shared defines header:
  - `DATA_BUS`, `FUNCT_BUS`, `FUNCT_DIV`, `FUNCT_DIVU`, `FUNCT_REM`, `FUNCT_REMU`.
  - FSM state encoding: localparams IDLE=2'd0, BUSY=2'd1, DONE=2'd2.
- One sub-module, `div_cache`:
  - Holds the tag (op1, op2, signed), the data (quo, rem) and the valid bit.
  - Inputs: write-enable and lookup.
  - Output: a combinational hit.
- `Divider` is instantiated by the EX-stage top beside `div_ctrl`, not inside it.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles, start requested, release → every output is 0 and the FSM is in IDLE. A start request held during reset is ignored.
- **DIVU 100/7, DIV_CYCLES=4:** `stall_req` high for cycles 0..4. `result`=14 with `result_valid` in cycle 5.
- **REM after DIV on the same operands** (-7 / 2): first op `result`=0xFFFFFFFD after 5 stall cycles. The following REM hits the cache and returns 0xFFFFFFFF after 1 stall cycle.
- **Divide by zero:**
  - DIV 5/0 → `result`=0xFFFFFFFF in cycle 1.
  - REMU 5/0 → `result`=5 in cycle 1.
- **Signed overflow:** DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 in cycle 1. REM of the same operands → 0.
- **Flush in BUSY cycle 2:** FSM returns to IDLE, no `result_valid`, `stall_req` is 0 in the flush cycle. Replaying the same op misses the cache and takes the full 5 stall cycles.
